// File: rtl/ip_ttl_csum_update.sv
// IPv4 TTL decrement and incremental header-checksum patch stage.
// Folds upstream partial sums, validates the header, flags bad/expired packets for drop.
`timescale 1ns/1ps

module ip_ttl_csum_update #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24,
  parameter int COUNTER_WIDTH        = 32
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
  input  logic                                 S_AXIS_TVALID,
  input  logic                                 S_AXIS_TLAST,
  output logic                                 S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
  output logic                                 M_AXIS_TVALID,
  output logic                                 M_AXIS_TLAST,
  input  logic                                 M_AXIS_TREADY,
  input  logic [31:0]                          checksum11,
  input  logic [31:0]                          checksum12,
  output logic [COUNTER_WIDTH-1:0]             ip_fwd_count,
  output logic [COUNTER_WIDTH-1:0]             bad_csum_count,
  output logic [COUNTER_WIDTH-1:0]             ttl_exp_count
);

  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  // One's-complement fold of the two 32-bit partial sums down to 16 bits.
  function automatic logic [15:0] fold_csum(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [17:0] f1;
    logic [16:0] f2;
    logic [15:0] f;
    s  = {1'b0, a} + {1'b0, b};
    f1 = {2'b00, s[15:0]} + {2'b00, s[31:16]} + {17'd0, s[32]};
    f2 = {1'b0, f1[15:0]} + {15'd0, f1[17:16]};
    f  = f2[15:0] + {15'd0, f2[16]};
    return f;
  endfunction

  // TTL occupies the high byte of its header word, so a decrement adds 0x0100 to the checksum.
  function automatic logic [15:0] patch_csum(input logic [15:0] csum);
    logic [16:0] c;
    c = {1'b0, csum} + 17'h00100;
    return c[15:0] + {15'd0, c[16]};
  endfunction

  state_t                            state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
  logic [STRB_W-1:0]                 hold_strb_q, hold_strb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   hold_user_q, hold_user_d;
  logic                              hold_last_q, hold_last_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [STRB_W-1:0]                 out_strb_q, out_strb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   out_user_q, out_user_d;
  logic                              out_last_q, out_last_d;
  logic                              out_valid_q, out_valid_d;
  logic [COUNTER_WIDTH-1:0]          fwd_cnt_q, fwd_cnt_d;
  logic [COUNTER_WIDTH-1:0]          bad_cnt_q, bad_cnt_d;
  logic [COUNTER_WIDTH-1:0]          exp_cnt_q, exp_cnt_d;

  logic                              s_ready_s;
  logic                              out_free_s;
  logic [15:0]                       folded_s;
  logic                              is_ipv4_s;
  logic                              csum_ok_s;
  logic                              ttl_expired_s;

  assign out_free_s    = ~out_valid_q | M_AXIS_TREADY;
  assign folded_s      = fold_csum(checksum11, checksum12);
  assign csum_ok_s     = (folded_s == 16'hFFFF);
  // Single-beat frames are excluded: upstream sums are stale for them.
  assign is_ipv4_s     = (hold_data_q[159:144] == 16'h0800) && (hold_data_q[143:136] == 8'h45) && !hold_last_q;
  assign ttl_expired_s = (hold_data_q[79:72] <= 8'd1);

  // Next-state, hold/output register loading and counter updates.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_strb_d = hold_strb_q;
    hold_user_d = hold_user_q;
    hold_last_d = hold_last_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~M_AXIS_TREADY;
    fwd_cnt_d   = fwd_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    s_ready_s   = 1'b0;

    case (state_q)
      ST_SOP: begin
        s_ready_s = 1'b1;
        if (S_AXIS_TVALID) begin
          hold_data_d = S_AXIS_TDATA;
          hold_strb_d = S_AXIS_TSTRB;
          hold_user_d = S_AXIS_TUSER;
          hold_last_d = S_AXIS_TLAST;
          state_d     = ST_CALC;
        end else begin
          state_d = ST_SOP;
        end
      end

      ST_CALC: begin
        if (is_ipv4_s) begin
          if (!csum_ok_s) begin
            hold_user_d[DST_PORT_POS +: 8] = 8'h00;
            bad_cnt_d = bad_cnt_q + CNT_ONE;
          end else if (ttl_expired_s) begin
            hold_user_d[DST_PORT_POS +: 8] = 8'h00;
            exp_cnt_d = exp_cnt_q + CNT_ONE;
          end else begin
            hold_data_d[79:72] = hold_data_q[79:72] - 8'd1;
            hold_data_d[63:48] = patch_csum(hold_data_q[63:48]);
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
          end
        end else begin
          hold_data_d = hold_data_q;
        end
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (out_free_s) begin
          out_data_d  = hold_data_q;
          out_strb_d  = hold_strb_q;
          out_user_d  = hold_user_q;
          out_last_d  = hold_last_q;
          out_valid_d = 1'b1;
          state_d     = hold_last_q ? ST_SOP : ST_BODY;
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_BODY: begin
        s_ready_s = out_free_s;
        if (S_AXIS_TVALID && out_free_s) begin
          out_data_d  = S_AXIS_TDATA;
          out_strb_d  = S_AXIS_TSTRB;
          out_user_d  = S_AXIS_TUSER;
          out_last_d  = S_AXIS_TLAST;
          out_valid_d = 1'b1;
          state_d     = S_AXIS_TLAST ? ST_SOP : ST_BODY;
        end else begin
          state_d = ST_BODY;
        end
      end

      default: begin
        state_d = ST_SOP;
      end
    endcase
  end

  // State, hold, output and counter registers.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q     <= ST_SOP;
      hold_data_q <= '0;
      hold_strb_q <= '0;
      hold_user_q <= '0;
      hold_last_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fwd_cnt_q   <= '0;
      bad_cnt_q   <= '0;
      exp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_strb_q <= hold_strb_d;
      hold_user_q <= hold_user_d;
      hold_last_q <= hold_last_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      fwd_cnt_q   <= fwd_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
    end
  end

  assign S_AXIS_TREADY  = s_ready_s;
  assign M_AXIS_TDATA   = out_data_q;
  assign M_AXIS_TSTRB   = out_strb_q;
  assign M_AXIS_TUSER   = out_user_q;
  assign M_AXIS_TLAST   = out_last_q;
  assign M_AXIS_TVALID  = out_valid_q;
  assign ip_fwd_count   = fwd_cnt_q;
  assign bad_csum_count = bad_cnt_q;
  assign ttl_exp_count  = exp_cnt_q;

endmodule

// File: tb/tb_ip_ttl_csum_update.sv
// Directed bench for ip_ttl_csum_update: forward, wrap, bad checksum, TTL expiry,
// pass-through, back-to-back with random backpressure, and mid-packet reset.
`timescale 1ns/1ps

module tb_ip_ttl_csum_update;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic [31:0]  c11 = '0;
  logic [31:0]  c12 = '0;
  logic [31:0]  fwd_cnt, bad_cnt, exp_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int tready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  int stall_err = 0;

  logic [255:0] cap_d[$], exp_d[$];
  logic [127:0] cap_u[$], exp_u[$];
  logic         cap_l[$], exp_l[$];
  logic [31:0]  cap_s[$], exp_s[$];

  localparam logic [127:0] U0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_04FF_EEDD;

  ip_ttl_csum_update dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .checksum11(c11), .checksum12(c12),
    .ip_fwd_count(fwd_cnt), .bad_csum_count(bad_cnt), .ttl_exp_count(exp_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tready_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else m_tready = (tready_mode == 0);
  end

  logic         prev_stall = 1'b0;
  logic [255:0] prev_d;
  logic [127:0] prev_u;
  logic         prev_l;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tuser !== prev_u || m_tlast !== prev_l))
        stall_err++;
      if (m_tvalid && m_tready) begin
        cap_d.push_back(m_tdata); cap_u.push_back(m_tuser);
        cap_l.push_back(m_tlast); cap_s.push_back(m_tstrb);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata; prev_u = m_tuser; prev_l = m_tlast;
    end
  end

  function automatic logic [255:0] mk(input logic [15:0] et, input logic [7:0] b14,
                                      input logic [7:0] ttl, input logic [15:0] cs, input logic [7:0] tag);
    return {48'h0000_5E00_0101, 48'h0200_0000_0001, et, b14, 8'h00, 16'h0073, 16'h0000,
            16'h4000, ttl, 8'h11, cs, 8'hC0, 8'hA8, 8'h00, tag, 16'h0A00};
  endfunction

  function automatic logic [255:0] body(input logic [7:0] tag, input logic [7:0] k);
    return {8{tag, k, 16'hA5C3}};
  endfunction

  task automatic clear_q();
    cap_d.delete(); cap_u.delete(); cap_l.delete(); cap_s.delete();
    exp_d.delete(); exp_u.delete(); exp_l.delete(); exp_s.delete();
  endtask

  task automatic drive_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
    logic hs;
    @(negedge clk);
    s_tdata = d; s_tstrb = s; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    hs = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #1;
      hs = s_tready;
      @(posedge clk);
      if (hs) break;
      @(negedge clk);
    end
    n_cmp++;
    if (!hs) begin
      n_fail++;
      $display("FAIL drive_beat: S_AXIS_TREADY never high, got %b want 1", hs);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [255:0] b0, input logic [255:0] xb0, input logic [127:0] u,
                          input logic [127:0] xu, input int nb, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] tag);
    logic [255:0] d;
    logic [31:0]  s;
    logic         l;
    c11 = a; c12 = b;
    for (int k = 0; k < nb; k++) begin
      d = (k == 0) ? b0 : body(tag, 8'(k));
      l = (k == nb - 1);
      s = l ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
      exp_d.push_back((k == 0) ? xb0 : d);
      exp_u.push_back((k == 0) ? xu : u);
      exp_l.push_back(l);
      exp_s.push_back(s);
      drive_beat(d, s, u, l);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && cap_d.size() < exp_d.size(); t++) begin
      @(negedge clk); #2;
    end
    repeat (3) begin @(negedge clk); #2; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_handshake: got tvalid=%b tready=%b want 0/1", m_tvalid, s_tready);
    end
    n_cmp++;
    if (fwd_cnt !== 32'd0 || bad_cnt !== 32'd0 || exp_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", fwd_cnt, bad_cnt, exp_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    clear_q();
    send_pkt(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h01), mk(16'h0800, 8'h45, 8'h3F, 16'hB961, 8'h01),
             U0, U0, 3, 32'h0000_FFFE, 32'h0000_0001, 8'h11);
    send_pkt(mk(16'h0800, 8'h45, 8'h20, 16'hFF10, 8'h02), mk(16'h0800, 8'h45, 8'h1F, 16'h0011, 8'h02),
             U0, U0, 2, 32'hFFFF_0000, 32'h0000_0000, 8'h22);
    idle(); drain();
    n_cmp++;
    if (cap_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL forward_count: got %0d beats want %0d", cap_d.size(), exp_d.size());
    end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_d[i] || cap_u[i] !== exp_u[i] || cap_l[i] !== exp_l[i] || cap_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL forward beat %0d: got d=%h u=%h l=%b s=%h want d=%h u=%h l=%b s=%h",
                 i, cap_d[i], cap_u[i], cap_l[i], cap_s[i], exp_d[i], exp_u[i], exp_l[i], exp_s[i]);
      end
    end
    n_cmp++;
    if (fwd_cnt !== 32'd2 || bad_cnt !== 32'd0 || exp_cnt !== 32'd0) begin
      n_fail++; $display("FAIL forward_counters: got %0d/%0d/%0d want 2/0/0", fwd_cnt, bad_cnt, exp_cnt);
    end
  endtask

  task automatic test_bad_csum();
    logic [127:0] ud;
    ud = U0; ud[31:24] = 8'h00;
    clear_q();
    send_pkt(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h03), mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h03),
             U0, ud, 2, 32'h0000_0000, 32'h0000_1234, 8'h33);
    idle(); drain();
    n_cmp++;
    if (cap_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL bad_csum_count_beats: got %0d want %0d", cap_d.size(), exp_d.size());
    end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_d[i] || cap_u[i] !== exp_u[i] || cap_l[i] !== exp_l[i] || cap_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL bad_csum beat %0d: got d=%h u=%h l=%b want d=%h u=%h l=%b",
                 i, cap_d[i], cap_u[i], cap_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (fwd_cnt !== 32'd2 || bad_cnt !== 32'd1 || exp_cnt !== 32'd0) begin
      n_fail++; $display("FAIL bad_csum_counters: got %0d/%0d/%0d want 2/1/0", fwd_cnt, bad_cnt, exp_cnt);
    end
  endtask

  task automatic test_ttl_expire();
    logic [127:0] ud;
    ud = U0; ud[31:24] = 8'h00;
    clear_q();
    send_pkt(mk(16'h0800, 8'h45, 8'h01, 16'hB861, 8'h04), mk(16'h0800, 8'h45, 8'h01, 16'hB861, 8'h04),
             U0, ud, 2, 32'h0000_FFFE, 32'h0000_0001, 8'h44);
    idle(); drain();
    n_cmp++;
    if (exp_cnt !== 32'd1) begin
      n_fail++; $display("FAIL ttl1_counter: got %0d want 1", exp_cnt);
    end
    send_pkt(mk(16'h0800, 8'h45, 8'h00, 16'hB861, 8'h05), mk(16'h0800, 8'h45, 8'h00, 16'hB861, 8'h05),
             U0, ud, 3, 32'h0000_FFFE, 32'h0000_0001, 8'h55);
    idle(); drain();
    n_cmp++;
    if (cap_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL ttl_expire_beats: got %0d want %0d", cap_d.size(), exp_d.size());
    end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_d[i] || cap_u[i] !== exp_u[i] || cap_l[i] !== exp_l[i] || cap_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL ttl_expire beat %0d: got d=%h u=%h l=%b want d=%h u=%h l=%b",
                 i, cap_d[i], cap_u[i], cap_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (fwd_cnt !== 32'd2 || bad_cnt !== 32'd1 || exp_cnt !== 32'd2) begin
      n_fail++; $display("FAIL ttl_expire_counters: got %0d/%0d/%0d want 2/1/2", fwd_cnt, bad_cnt, exp_cnt);
    end
  endtask

  task automatic test_passthrough();
    clear_q();
    send_pkt(mk(16'h0806, 8'h45, 8'h40, 16'hB861, 8'h06), mk(16'h0806, 8'h45, 8'h40, 16'hB861, 8'h06),
             U0, U0, 2, 32'h0000_FFFE, 32'h0000_0001, 8'h66);
    send_pkt(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h07), mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h07),
             U0, U0, 1, 32'h0000_FFFE, 32'h0000_0001, 8'h77);
    send_pkt(mk(16'h0800, 8'h46, 8'h40, 16'hB861, 8'h08), mk(16'h0800, 8'h46, 8'h40, 16'hB861, 8'h08),
             U0, U0, 2, 32'h0000_FFFE, 32'h0000_0001, 8'h88);
    idle(); drain();
    n_cmp++;
    if (cap_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL passthrough_beats: got %0d want %0d", cap_d.size(), exp_d.size());
    end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_d[i] || cap_u[i] !== exp_u[i] || cap_l[i] !== exp_l[i] || cap_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL passthrough beat %0d: got d=%h u=%h l=%b s=%h want d=%h u=%h l=%b s=%h",
                 i, cap_d[i], cap_u[i], cap_l[i], cap_s[i], exp_d[i], exp_u[i], exp_l[i], exp_s[i]);
      end
    end
    n_cmp++;
    if (fwd_cnt !== 32'd2 || bad_cnt !== 32'd1 || exp_cnt !== 32'd2) begin
      n_fail++; $display("FAIL passthrough_counters: got %0d/%0d/%0d want 2/1/2", fwd_cnt, bad_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] u;
    clear_q();
    stall_err = 0;
    tready_mode = 1;
    for (int p = 0; p < 20; p++) begin
      u = U0; u[127:120] = 8'(p);
      send_pkt(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'(p)), mk(16'h0800, 8'h45, 8'h3F, 16'hB961, 8'(p)),
               u, u, 4, 32'h0000_FFFE, 32'h0000_0001, 8'(8'h90 + p));
    end
    idle(); drain();
    tready_mode = 0;
    n_cmp++;
    if (cap_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL b2b_beats: got %0d want %0d", cap_d.size(), exp_d.size());
    end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== exp_d[i] || cap_u[i] !== exp_u[i] || cap_l[i] !== exp_l[i] || cap_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL b2b beat %0d: got d=%h u=%h l=%b want d=%h u=%h l=%b",
                 i, cap_d[i], cap_u[i], cap_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (stall_err !== 0) begin
      n_fail++; $display("FAIL b2b_stall_stable: got %0d unstable cycles want 0", stall_err);
    end
    n_cmp++;
    if (fwd_cnt !== 32'd22) begin
      n_fail++; $display("FAIL b2b_fwd_counter: got %0d want 22", fwd_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_q();
    tready_mode = 2;
    c11 = 32'h0000_FFFE; c12 = 32'h0000_0001;
    drive_beat(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h0A), 32'hFFFF_FFFF, U0, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b1 || fwd_cnt !== 32'd23) begin
      n_fail++; $display("FAIL midpkt_pre: got tvalid=%b fwd=%0d want 1/23", m_tvalid, fwd_cnt);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || fwd_cnt !== 32'd0 || bad_cnt !== 32'd0 || exp_cnt !== 32'd0) begin
      n_fail++; $display("FAIL midpkt_reset: got tvalid=%b cnt=%0d/%0d/%0d want 0 0/0/0",
                         m_tvalid, fwd_cnt, bad_cnt, exp_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    tready_mode = 0;
    clear_q();
    send_pkt(mk(16'h0800, 8'h45, 8'h40, 16'hB861, 8'h0B), mk(16'h0800, 8'h45, 8'h3F, 16'hB961, 8'h0B),
             U0, U0, 2, 32'h0000_FFFE, 32'h0000_0001, 8'hBB);
    idle(); drain();
    n_cmp++;
    if (cap_d.size() != 2 || cap_d[0] !== exp_d[0] || cap_d[1] !== exp_d[1] || cap_l[1] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_pkt: got %0d beats want 2 with patched header", cap_d.size());
    end
    n_cmp++;
    if (fwd_cnt !== 32'd1) begin
      n_fail++; $display("FAIL post_reset_counter: got %0d want 1", fwd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_bad_csum();
    test_ttl_expire();
    test_passthrough();
    test_back_to_back();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
